// File: rtl/ft601_emu_pkg.sv
// Shared constants and types for the FT601 device-side emulator.
package ft601_emu_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int BE_W_DEF   = 4;
  localparam int CNT_W      = 16;

  typedef logic [BE_W_DEF+DATA_W_DEF-1:0] ft_word_t;

endpackage

// File: rtl/ft601_emu_fifo.sv
// Show-ahead synchronous FIFO; also reports post-edge occupancy and head so the
// caller can register bus flags and drive data without an extra cycle of lag.
module ft601_emu_fifo #(
  parameter int DEPTH = 512,
  parameter int W     = 36
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_en_i,
  input  logic [W-1:0]             wr_data_i,
  input  logic                     rd_en_i,
  output logic [W-1:0]             rd_data_o,
  output logic [W-1:0]             next_head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     next_full_o,
  output logic                     next_empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW-1:0] rptr_p1;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;

  // A push into a full queue is honoured when a pop frees the slot on the same edge.
  assign pop     = rd_en_i & ~empty_o;
  assign push    = wr_en_i & (~full_o | pop);
  assign rptr_p1 = rptr_q + 1'b1;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_p1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  assign next_full_o  = (count_d == CW'(DEPTH));
  assign next_empty_o = (count_d == '0);

  always_comb begin
    next_head_o = mem_q[rptr_q];
    if (empty_o || (pop && count_q == CW'(1))) next_head_o = wr_data_i;
    else if (pop)                              next_head_o = mem_q[rptr_p1];
  end

  assign rd_data_o = empty_o ? '0 : mem_q[rptr_q];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/ft601_device_emulator.sv
// FT601 chip side of the 245 synchronous FIFO bus: accepts master reads/writes,
// exposes host-side queues, counts transfers and latches protocol violations.
module ft601_device_emulator
  import ft601_emu_pkg::*;
#(
  parameter int DEPTH  = 512,
  parameter int DATA_W = DATA_W_DEF,
  parameter int BE_W   = BE_W_DEF
) (
  input  logic                   Clock,
  input  logic                   Reset,
  output logic                   FTDI_nRXF,
  output logic                   FTDI_nTXE,
  input  logic                   FTDI_nRD,
  input  logic                   FTDI_nWR,
  input  logic                   FTDI_nOE,
  input  logic [DATA_W-1:0]      FTDI_DATA_i,
  output logic [DATA_W-1:0]      FTDI_DATA_o,
  output logic                   FTDI_DATA_oe,
  input  logic [BE_W-1:0]        FTDI_BE_i,
  output logic [BE_W-1:0]        FTDI_BE_o,
  output logic                   FTDI_BE_oe,
  input  logic [BE_W+DATA_W-1:0] Host_TX_Data,
  input  logic                   Host_TX_WE,
  output logic                   Host_TX_Full,
  output logic [BE_W+DATA_W-1:0] Host_RX_Data,
  input  logic                   Host_RX_RE,
  output logic                   Host_RX_Empty,
  output logic                   Protocol_Error,
  output logic [CNT_W-1:0]       Words_Read,
  output logic [CNT_W-1:0]       Words_Written
);

  localparam int WORD_W = BE_W + DATA_W;
  localparam int CW     = $clog2(DEPTH) + 1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != {CNT_W{1'b1}})) return v + 1'b1;
    return v;
  endfunction

  logic              nrxf_q, nrxf_d;
  logic              ntxe_q, ntxe_d;
  logic              oe_q, oe_d;
  logic              err_q, err_d;
  logic [WORD_W-1:0] head_q, head_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;

  logic rd_req, wr_req, oe_req, bus_clash, rd_acc, wr_acc, viol;

  logic [WORD_W-1:0] tx_next_head;
  logic              tx_next_empty, rx_next_full;
  logic [WORD_W-1:0] tx_data_unused, rx_head_unused;
  logic [CW-1:0]     tx_count_unused, rx_count_unused;
  logic              tx_nfull_unused, rx_full_unused, rx_nempty_unused, tx_empty_unused;

  assign rd_req    = ~FTDI_nRD;
  assign wr_req    = ~FTDI_nWR;
  assign oe_req    = ~FTDI_nOE;
  // Master driving data while asking us to drive too: refuse both transfers.
  assign bus_clash = wr_req & oe_req;
  assign rd_acc    = rd_req & oe_req & ~wr_req & ~nrxf_q;
  assign wr_acc    = wr_req & ~oe_req & ~ntxe_q;
  assign viol      = (rd_req & (nrxf_q | ~oe_req)) | (wr_req & ntxe_q) | bus_clash;

  ft601_emu_fifo #(.DEPTH(DEPTH), .W(WORD_W)) u_tx_fifo (
    .clk_i        (Clock),
    .rst_i        (Reset),
    .wr_en_i      (Host_TX_WE),
    .wr_data_i    (Host_TX_Data),
    .rd_en_i      (rd_acc),
    .rd_data_o    (tx_data_unused),
    .next_head_o  (tx_next_head),
    .count_o      (tx_count_unused),
    .full_o       (Host_TX_Full),
    .empty_o      (tx_empty_unused),
    .next_full_o  (tx_nfull_unused),
    .next_empty_o (tx_next_empty)
  );

  ft601_emu_fifo #(.DEPTH(DEPTH), .W(WORD_W)) u_rx_fifo (
    .clk_i        (Clock),
    .rst_i        (Reset),
    .wr_en_i      (wr_acc),
    .wr_data_i    ({FTDI_BE_i, FTDI_DATA_i}),
    .rd_en_i      (Host_RX_RE),
    .rd_data_o    (Host_RX_Data),
    .next_head_o  (rx_head_unused),
    .count_o      (rx_count_unused),
    .full_o       (rx_full_unused),
    .empty_o      (Host_RX_Empty),
    .next_full_o  (rx_next_full),
    .next_empty_o (rx_nempty_unused)
  );

  // Flags and drive data track occupancy after this edge, so a master obeying
  // the flags in the same cycle can never overrun or underrun a queue.
  always_comb begin
    nrxf_d   = tx_next_empty;
    ntxe_d   = rx_next_full;
    oe_d     = oe_req;
    err_d    = err_q | viol;
    head_d   = head_q;
    if (!tx_next_empty) head_d = tx_next_head;
    rd_cnt_d = sat_inc(rd_cnt_q, rd_acc);
    wr_cnt_d = sat_inc(wr_cnt_q, wr_acc);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      nrxf_q   <= 1'b1;
      ntxe_q   <= 1'b1;
      oe_q     <= 1'b0;
      err_q    <= 1'b0;
      head_q   <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      nrxf_q   <= nrxf_d;
      ntxe_q   <= ntxe_d;
      oe_q     <= oe_d;
      err_q    <= err_d;
      head_q   <= head_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign FTDI_nRXF      = nrxf_q;
  assign FTDI_nTXE      = ntxe_q;
  assign FTDI_DATA_oe   = oe_q;
  assign FTDI_BE_oe     = oe_q;
  assign FTDI_DATA_o    = head_q[DATA_W-1:0];
  assign FTDI_BE_o      = head_q[WORD_W-1:DATA_W];
  assign Protocol_Error = err_q;
  assign Words_Read     = rd_cnt_q;
  assign Words_Written  = wr_cnt_q;

endmodule
